// File: rtl/mx_alu_out_serializer_if.sv
// Output stream bus of the MX ALU serializer: one beat of LANES elements plus
// block-level side information (shared scale, scalar result) and framing.
interface mx_alu_out_serializer_if #(
    parameter int unsigned D     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned S     = 32,
    parameter int unsigned LANES = 4
);
    logic               m_valid;
    logic               m_ready;
    logic [LANES*D-1:0] m_data;
    logic               m_first;
    logic               m_last;
    logic [W-1:0]       m_scale;
    logic [S-1:0]       m_scalar;

    modport master (
        output m_valid, m_data, m_first, m_last, m_scale, m_scalar,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_first, m_last, m_scale, m_scalar,
        output m_ready
    );
endinterface

// File: rtl/mx_alu_out_serializer.sv
// Captures MX ALU result blocks into a 2-entry FIFO and streams each block's
// elements LANES at a time with first/last framing. The ALU cannot be stalled,
// so a block arriving at a full FIFO is dropped and a sticky overflow is raised.
module mx_alu_out_serializer #(
    parameter int unsigned D     = 8,
    parameter int unsigned K     = 32,
    parameter int unsigned W     = 8,
    parameter int unsigned S     = 32,
    parameter int unsigned LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [W+K*D-1:0]             in_vec,
    input  logic [S-1:0]                 in_scalar,
    mx_alu_out_serializer_if.master      m,
    output logic [1:0]                   occupancy,
    output logic                         ovf,
    input  logic                         ovf_clr
);
    localparam int unsigned VW = W + K * D;
    localparam int unsigned NB = K / LANES;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned BD = LANES * D;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [VW-1:0] vec_q [2];
    logic [S-1:0]  scl_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q, count_d, count_after_pop;
    logic [BW-1:0] beat_q, beat_d;
    state_e        state_q, state_d;
    logic          ovf_q, ovf_d;

    logic          stream, last_beat, hs, pop, wr, drop;
    logic [VW-1:0] head_vec;
    logic [K*D-1:0] elems;

    // Handshake, pop and write/drop decisions; a same-cycle final pop frees a slot.
    always_comb begin
        stream          = (state_q == StStream);
        last_beat       = (beat_q == BW'(NB - 1));
        hs              = stream & m.m_ready;
        pop             = hs & last_beat;
        count_after_pop = count_q - {1'b0, pop};
        wr              = in_valid & (count_after_pop != 2'd2);
        drop            = in_valid & ~wr;
        count_d         = count_after_pop + {1'b0, wr};
        // Setting the overflow flag wins over a same-cycle clear.
        ovf_d           = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // Streaming FSM next-state and beat counter.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != 2'd0) begin
                    state_d = StStream;
                    beat_d  = '0;
                end
            end
            StStream: begin
                if (hs) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (count_after_pop == 2'd0) state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Beat outputs muxed from the head entry; zero while idle.
    always_comb begin
        head_vec   = vec_q[rd_ptr_q];
        elems      = head_vec[VW-1:W];
        m.m_valid  = stream;
        m.m_data   = stream ? elems[32'(beat_q) * BD +: BD] : '0;
        m.m_first  = stream & (beat_q == '0);
        m.m_last   = stream & last_beat;
        m.m_scale  = stream ? head_vec[W-1:0] : '0;
        m.m_scalar = stream ? scl_q[rd_ptr_q] : '0;
        occupancy  = count_q;
        ovf        = ovf_q;
    end

    // FIFO storage, pointers, counters and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q[0] <= '0;
            vec_q[1] <= '0;
            scl_q[0] <= '0;
            scl_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            beat_q   <= '0;
            state_q  <= StIdle;
            ovf_q    <= 1'b0;
        end else begin
            if (wr) begin
                vec_q[wr_ptr_q] <= in_vec;
                scl_q[wr_ptr_q] <= in_scalar;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            beat_q  <= beat_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mx_alu_out_serializer.sv
// Directed bench for mx_alu_out_serializer: a LANES=4 instance for the
// streaming/overflow/reset scenarios and a LANES=32 instance for single-beat blocks.
module tb_mx_alu_out_serializer;
    localparam int unsigned D  = 8;
    localparam int unsigned K  = 32;
    localparam int unsigned W  = 8;
    localparam int unsigned S  = 32;
    localparam int unsigned NB = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_valid32 = 1'b0;
    logic [W+K*D-1:0] in_vec = '0;
    logic [S-1:0]     in_scalar = '0;
    logic             ovf_clr = 1'b0;
    logic [1:0]       occupancy, occ32;
    logic             ovf, ovf32;

    int checks = 0;
    int errors = 0;

    // Block injected on the final handshake of a drain (simultaneous write case).
    logic [7:0]  inj_scale, inj_base;
    logic [31:0] inj_scalar;

    mx_alu_out_serializer_if #(.D(D), .W(W), .S(S), .LANES(4))  bus ();
    mx_alu_out_serializer_if #(.D(D), .W(W), .S(S), .LANES(32)) bus32 ();

    mx_alu_out_serializer #(.D(D), .K(K), .W(W), .S(S), .LANES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .in_scalar (in_scalar),
        .m         (bus),
        .occupancy (occupancy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    mx_alu_out_serializer #(.D(D), .K(K), .W(W), .S(S), .LANES(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_vec    (in_vec),
        .in_scalar (in_scalar),
        .m         (bus32),
        .occupancy (occ32),
        .ovf       (ovf32),
        .ovf_clr   (1'b0)
    );

    always #5 clk = ~clk;

    function automatic logic [W+K*D-1:0] make_vec(input logic [7:0] scale, input logic [7:0] base);
        logic [W+K*D-1:0] v;
        v = '0;
        v[7:0] = scale;
        for (int i = 0; i < K; i++) v[8 + i*8 +: 8] = base + 8'(i);
        return v;
    endfunction

    function automatic logic [31:0] exp_beat(input logic [7:0] base, input int b);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = base + 8'(4*b + j);
        return r;
    endfunction

    // Pulse in_valid for one cycle; called and returns at a falling edge.
    task automatic send(input logic [7:0] scale, input logic [7:0] base, input logic [31:0] scalar);
        in_vec    = make_vec(scale, base);
        in_scalar = scalar;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Stream one block out, checking every presented beat; optional stall and injection.
    task automatic drain(input logic [7:0] scale, input logic [7:0] base, input logic [31:0] scalar,
                         input int stall_beat, input int stall_n, input bit inject);
        int n = 0;
        int beat = 0;
        int stalled = 0;
        int cyc = 0;
        bit hs;
        logic [31:0] exp;
        while (!bus.m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_start: m_valid=%b required 1", bus.m_valid);
            return;
        end
        while (beat < NB && cyc < 40) begin
            exp = exp_beat(base, beat);
            checks++;
            if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL beat%0d_valid: got %b required 1", beat, bus.m_valid); end
            checks++;
            if (bus.m_data !== exp) begin errors++; $display("FAIL beat%0d_data: got %h required %h", beat, bus.m_data, exp); end
            checks++;
            if (bus.m_first !== (beat == 0)) begin errors++; $display("FAIL beat%0d_first: got %b required %b", beat, bus.m_first, beat == 0); end
            checks++;
            if (bus.m_last !== (beat == NB-1)) begin errors++; $display("FAIL beat%0d_last: got %b required %b", beat, bus.m_last, beat == NB-1); end
            checks++;
            if (bus.m_scale !== scale) begin errors++; $display("FAIL beat%0d_scale: got %h required %h", beat, bus.m_scale, scale); end
            checks++;
            if (bus.m_scalar !== scalar) begin errors++; $display("FAIL beat%0d_scalar: got %h required %h", beat, bus.m_scalar, scalar); end
            if (beat == stall_beat && stalled < stall_n) begin
                bus.m_ready = 1'b0;
                stalled++;
            end else begin
                bus.m_ready = 1'b1;
            end
            if (inject && beat == NB-1 && bus.m_ready) begin
                in_vec    = make_vec(inj_scale, inj_base);
                in_scalar = inj_scalar;
                in_valid  = 1'b1;
            end
            hs = bus.m_valid && bus.m_ready;
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            if (hs) beat++;
        end
        bus.m_ready = 1'b0;
        checks++;
        if (beat != NB) begin errors++; $display("FAIL drain_beats: got %0d required %0d", beat, NB); end
        checks++;
        if (cyc != NB + stalled) begin errors++; $display("FAIL drain_cycles: got %0d required %0d", cyc, NB + stalled); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.m_valid); end
        checks++;
        if (bus.m_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", bus.m_data); end
        checks++;
        if ({bus.m_first, bus.m_last} !== 2'b00) begin errors++; $display("FAIL reset_framing: got %b required 00", {bus.m_first, bus.m_last}); end
        checks++;
        if (occupancy !== 2'd0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_occ_ovf: got %0d/%b required 0/0", occupancy, ovf); end
        checks++;
        if (bus.m_scale !== 8'h0 || bus.m_scalar !== 32'h0) begin errors++; $display("FAIL reset_side: got %h/%h required 0/0", bus.m_scale, bus.m_scalar); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_one_block();
        bus.m_ready = 1'b1;
        send(8'h7F, 8'h00, 32'hDEADBEEF);
        checks++;
        if (bus.m_valid !== 1'b0 || occupancy !== 2'd1) begin errors++; $display("FAIL one_latency0: valid/occ got %b/%0d required 0/1", bus.m_valid, occupancy); end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h03020100) begin errors++; $display("FAIL one_latency1: valid/data got %b/%h required 1/03020100", bus.m_valid, bus.m_data); end
        drain(8'h7F, 8'h00, 32'hDEADBEEF, -1, 0, 1'b0);
        checks++;
        if (bus.m_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL one_idle: valid/occ got %b/%0d required 0/0", bus.m_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        bus.m_ready = 1'b1;
        send(8'h7F, 8'h00, 32'hDEADBEEF);
        drain(8'h7F, 8'h00, 32'hDEADBEEF, 2, 3, 1'b0);
        checks++;
        if (bus.m_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_idle: valid/occ got %b/%0d required 0/0", bus.m_valid, occupancy); end
    endtask

    task automatic test_overflow();
        bus.m_ready = 1'b0;
        send(8'h01, 8'h10, 32'h00000001);
        send(8'h02, 8'h40, 32'h00000002);
        send(8'h03, 8'h80, 32'h00000003);
        checks++;
        if (occupancy !== 2'd2) begin errors++; $display("FAIL ovf_occ: got %0d required 2", occupancy); end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", ovf); end
        drain(8'h01, 8'h10, 32'h00000001, -1, 0, 1'b0);
        drain(8'h02, 8'h40, 32'h00000002, -1, 0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL ovf_no_third: valid/occ got %b/%0d required 0/0", bus.m_valid, occupancy); end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", ovf); end
    endtask

    task automatic test_back_to_back();
        bus.m_ready = 1'b0;
        send(8'h0A, 8'h20, 32'hAAAA0001);
        send(8'h0B, 8'h50, 32'hBBBB0002);
        checks++;
        if (occupancy !== 2'd2) begin errors++; $display("FAIL b2b_full: got %0d required 2", occupancy); end
        inj_scale  = 8'h0C;
        inj_base   = 8'h90;
        inj_scalar = 32'hCCCC0003;
        drain(8'h0A, 8'h20, 32'hAAAA0001, -1, 0, 1'b1);
        checks++;
        if (occupancy !== 2'd2) begin errors++; $display("FAIL simul_occ: got %0d required 2", occupancy); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b required 0", ovf); end
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_first !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: valid/first got %b/%b required 1/1", bus.m_valid, bus.m_first); end
        drain(8'h0B, 8'h50, 32'hBBBB0002, -1, 0, 1'b0);
        drain(8'h0C, 8'h90, 32'hCCCC0003, -1, 0, 1'b0);
        checks++;
        if (bus.m_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL b2b_idle: valid/occ got %b/%0d required 0/0", bus.m_valid, occupancy); end
    endtask

    task automatic test_reset_mid_block();
        int n = 0;
        bus.m_ready = 1'b1;
        send(8'h55, 8'h00, 32'h55555555);
        while (!bus.m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.m_data !== 32'h13121110) begin errors++; $display("FAIL rst_mid_beat4: got %h required 13121110", bus.m_data); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL rst_mid_clear: valid/occ got %b/%0d required 0/0", bus.m_valid, occupancy); end
        checks++;
        if (bus.m_data !== 32'h0 || bus.m_first !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: data/first got %h/%b required 0/0", bus.m_data, bus.m_first); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stays_idle: got %b required 0", bus.m_valid); end
        bus.m_ready = 1'b1;
        send(8'h66, 8'h40, 32'h12345678);
        drain(8'h66, 8'h40, 32'h12345678, -1, 0, 1'b0);
        checks++;
        if (bus.m_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL rst_mid_after: valid/occ got %b/%0d required 0/0", bus.m_valid, occupancy); end
    endtask

    task automatic test_single_beat_lanes();
        int n = 0;
        logic [W+K*D-1:0] v;
        bus32.m_ready = 1'b1;
        v = make_vec(8'h33, 8'hA0);
        in_vec     = v;
        in_scalar  = 32'hCAFEF00D;
        in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        while (!bus32.m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus32.m_valid !== 1'b1) begin errors++; $display("FAIL l32_valid: got %b required 1", bus32.m_valid); end
        checks++;
        if ({bus32.m_first, bus32.m_last} !== 2'b11) begin errors++; $display("FAIL l32_framing: got %b required 11", {bus32.m_first, bus32.m_last}); end
        checks++;
        if (bus32.m_data !== v[W+K*D-1:W]) begin errors++; $display("FAIL l32_data: got %h required %h", bus32.m_data, v[W+K*D-1:W]); end
        checks++;
        if (bus32.m_scale !== 8'h33 || bus32.m_scalar !== 32'hCAFEF00D) begin errors++; $display("FAIL l32_side: got %h/%h required 33/cafef00d", bus32.m_scale, bus32.m_scalar); end
        @(negedge clk);
        checks++;
        if (bus32.m_valid !== 1'b0 || occ32 !== 2'd0) begin errors++; $display("FAIL l32_done: valid/occ got %b/%0d required 0/0", bus32.m_valid, occ32); end
    endtask

    initial begin
        bus.m_ready   = 1'b0;
        bus32.m_ready = 1'b0;
        inj_scale     = '0;
        inj_base      = '0;
        inj_scalar    = '0;
        test_reset();
        test_one_block();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid_block();
        test_single_beat_lanes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
